// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC arbiter slice.
package cordic_pkg;

    localparam int WORD_WIDTH_DEF = 20;

    typedef struct packed {
        logic signed [WORD_WIDTH_DEF-1:0] x;
        logic signed [WORD_WIDTH_DEF-1:0] y;
        logic signed [WORD_WIDTH_DEF-1:0] z;
    } cordic_vec_t;

    typedef logic [0:0] chan_t;

    localparam chan_t CH0 = 1'b0;
    localparam chan_t CH1 = 1'b1;

endpackage

// File: rtl/cordic_arb_fifo.sv
// Synchronous FIFO with occupancy count and first-word-fall-through output.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module cordic_arb_fifo
    import cordic_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    // Empty FIFO presents zeros so outputs are clean straight out of reset.
    assign dout     = empty ? T'('0) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one fixed-latency CORDIC pipeline between two requesters,
// with credit-protected per-channel result FIFOs. Optional counters: CORDIC_ARBITER_STATS_EN.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int LATENCY    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s0_vld_i,
    output logic                         s0_rdy_o,
    input  logic signed [WORD_WIDTH-1:0] s0_x_i,
    input  logic signed [WORD_WIDTH-1:0] s0_y_i,
    input  logic signed [WORD_WIDTH-1:0] s0_z_i,
    input  logic                         s1_vld_i,
    output logic                         s1_rdy_o,
    input  logic signed [WORD_WIDTH-1:0] s1_x_i,
    input  logic signed [WORD_WIDTH-1:0] s1_y_i,
    input  logic signed [WORD_WIDTH-1:0] s1_z_i,
    output logic                         m0_vld_o,
    input  logic                         m0_rdy_i,
    output logic signed [WORD_WIDTH-1:0] m0_x_o,
    output logic signed [WORD_WIDTH-1:0] m0_y_o,
    output logic signed [WORD_WIDTH-1:0] m0_z_o,
    output logic                         m1_vld_o,
    input  logic                         m1_rdy_i,
    output logic signed [WORD_WIDTH-1:0] m1_x_o,
    output logic signed [WORD_WIDTH-1:0] m1_y_o,
    output logic signed [WORD_WIDTH-1:0] m1_z_o,
    output logic                         c_vld_o,
    output logic signed [WORD_WIDTH-1:0] c_x_o,
    output logic signed [WORD_WIDTH-1:0] c_y_o,
    output logic signed [WORD_WIDTH-1:0] c_z_o,
    input  logic                         c_vld_i,
    input  logic signed [WORD_WIDTH-1:0] c_x_i,
    input  logic signed [WORD_WIDTH-1:0] c_y_i,
    input  logic signed [WORD_WIDTH-1:0] c_z_i,
    output logic                         err_o
`ifdef CORDIC_ARBITER_STATS_EN
    ,
    output logic [31:0]                  stat_gnt0_o,
    output logic [31:0]                  stat_gnt1_o,
    output logic [31:0]                  stat_stall_o
`endif
);

    localparam int CRW       = $clog2(FIFO_DEPTH + 1);
    localparam int TAG_DEPTH = LATENCY + 1;

    typedef struct packed {
        logic signed [WORD_WIDTH-1:0] x;
        logic signed [WORD_WIDTH-1:0] y;
        logic signed [WORD_WIDTH-1:0] z;
    } vec_t;

    logic [CRW-1:0] credit0;
    logic [CRW-1:0] credit1;
    chan_t          rr_ptr;
    logic           elig0;
    logic           elig1;
    logic           gnt0;
    logic           gnt1;
    logic           pop0;
    logic           pop1;

    chan_t          tag_din;
    chan_t          tag_dout;
    logic           tag_empty;
    logic           tag_full;
    logic           tag_ovf;
    logic [$clog2(TAG_DEPTH+1)-1:0] tag_cnt;

    logic           ret_vld;
    vec_t           ret_vec;
    vec_t           res0;
    vec_t           res1;
    logic           empty0;
    logic           empty1;
    logic           full0;
    logic           full1;
    logic           ovf0;
    logic           ovf1;
    logic [CRW-1:0] cnt0;
    logic [CRW-1:0] cnt1;
    logic           unused_fifo;

    // rr_ptr names the channel favoured on the next tie; it flips to the loser after each grant.
    always_comb begin
        elig0 = s0_vld_i && (credit0 != '0);
        elig1 = s1_vld_i && (credit1 != '0);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (elig0 && elig1) begin
            gnt0 = (rr_ptr == CH0);
            gnt1 = (rr_ptr == CH1);
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
    end

    assign s0_rdy_o = gnt0;
    assign s1_rdy_o = gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld_o <= 1'b0;
            c_x_o   <= '0;
            c_y_o   <= '0;
            c_z_o   <= '0;
            rr_ptr  <= CH0;
        end else begin
            c_vld_o <= gnt0 || gnt1;
            if (gnt0) begin
                c_x_o  <= s0_x_i;
                c_y_o  <= s0_y_i;
                c_z_o  <= s0_z_i;
                rr_ptr <= CH1;
            end else if (gnt1) begin
                c_x_o  <= s1_x_i;
                c_y_o  <= s1_y_i;
                c_z_o  <= s1_z_i;
                rr_ptr <= CH0;
            end
        end
    end

    assign tag_din = gnt1 ? CH1 : CH0;

    cordic_arb_fifo #(
        .DEPTH (TAG_DEPTH),
        .T     (chan_t)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (gnt0 || gnt1),
        .din      (tag_din),
        .pop      (c_vld_i),
        .dout     (tag_dout),
        .empty    (tag_empty),
        .full     (tag_full),
        .count    (tag_cnt),
        .overflow (tag_ovf)
    );

    assign ret_vld = c_vld_i && !tag_empty;
    assign ret_vec = {c_x_i, c_y_i, c_z_i};

    cordic_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (vec_t)
    ) u_res0_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ret_vld && (tag_dout == CH0)),
        .din      (ret_vec),
        .pop      (pop0),
        .dout     (res0),
        .empty    (empty0),
        .full     (full0),
        .count    (cnt0),
        .overflow (ovf0)
    );

    cordic_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (vec_t)
    ) u_res1_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ret_vld && (tag_dout == CH1)),
        .din      (ret_vec),
        .pop      (pop1),
        .dout     (res1),
        .empty    (empty1),
        .full     (full1),
        .count    (cnt1),
        .overflow (ovf1)
    );

    assign m0_vld_o = !empty0;
    assign m1_vld_o = !empty1;
    assign m0_x_o   = res0.x;
    assign m0_y_o   = res0.y;
    assign m0_z_o   = res0.z;
    assign m1_x_o   = res1.x;
    assign m1_y_o   = res1.y;
    assign m1_z_o   = res1.z;
    assign pop0     = m0_vld_o && m0_rdy_i;
    assign pop1     = m1_vld_o && m1_rdy_i;

    // A grant and a pop on the same channel in one cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit0 <= CRW'(FIFO_DEPTH);
            credit1 <= CRW'(FIFO_DEPTH);
        end else begin
            case ({gnt0, pop0})
                2'b10:   credit0 <= credit0 - CRW'(1);
                2'b01:   credit0 <= credit0 + CRW'(1);
                default: credit0 <= credit0;
            endcase
            case ({gnt1, pop1})
                2'b10:   credit1 <= credit1 - CRW'(1);
                2'b01:   credit1 <= credit1 + CRW'(1);
                default: credit1 <= credit1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if ((c_vld_i && tag_empty) || ovf0 || ovf1) begin
            err_o <= 1'b1;
        end
    end

    assign unused_fifo = ^{tag_cnt, tag_full, tag_ovf, cnt0, cnt1, full0, full1};

`ifdef CORDIC_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_gnt0_o  <= '0;
            stat_gnt1_o  <= '0;
            stat_stall_o <= '0;
        end else begin
            if (gnt0) begin
                stat_gnt0_o <= stat_gnt0_o + 32'd1;
            end
            if (gnt1) begin
                stat_gnt1_o <= stat_gnt1_o + 32'd1;
            end
            if ((s0_vld_i || s1_vld_i) && !(gnt0 || gnt1)) begin
                stat_stall_o <= stat_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with an identity CORDIC model of fixed latency.
module tb_cordic_arbiter;

    localparam int W   = 20;
    localparam int LAT = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s0_vld, s1_vld, s0_rdy, s1_rdy;
    logic [W-1:0] s0_x, s0_y, s0_z, s1_x, s1_y, s1_z;
    logic         m0_vld, m1_vld, m0_rdy, m1_rdy;
    logic [W-1:0] m0_x, m0_y, m0_z, m1_x, m1_y, m1_z;
    logic         c_vld_o, c_vld_i;
    logic [W-1:0] c_x_o, c_y_o, c_z_o, c_x_i, c_y_i, c_z_i;
    logic         err;
    logic         inj;

    logic [3*W:0]   pipe [LAT];
    logic [3*W-1:0] q0[$], q1[$];
    int             gq[$];
    logic [3*W-1:0] e0, e1;
    logic           r0, r1;
    int             n_tests = 0;
    int             n_fail  = 0;

    always #5 clk = ~clk;

    cordic_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_vld_i (s0_vld),
        .s0_rdy_o (s0_rdy),
        .s0_x_i   (s0_x),
        .s0_y_i   (s0_y),
        .s0_z_i   (s0_z),
        .s1_vld_i (s1_vld),
        .s1_rdy_o (s1_rdy),
        .s1_x_i   (s1_x),
        .s1_y_i   (s1_y),
        .s1_z_i   (s1_z),
        .m0_vld_o (m0_vld),
        .m0_rdy_i (m0_rdy),
        .m0_x_o   (m0_x),
        .m0_y_o   (m0_y),
        .m0_z_o   (m0_z),
        .m1_vld_o (m1_vld),
        .m1_rdy_i (m1_rdy),
        .m1_x_o   (m1_x),
        .m1_y_o   (m1_y),
        .m1_z_o   (m1_z),
        .c_vld_o  (c_vld_o),
        .c_x_o    (c_x_o),
        .c_y_o    (c_y_o),
        .c_z_o    (c_z_o),
        .c_vld_i  (c_vld_i),
        .c_x_i    (c_x_i),
        .c_y_i    (c_y_i),
        .c_z_i    (c_z_i),
        .err_o    (err)
    );

    // Identity CORDIC: LAT register stages, reset together with the arbiter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {c_vld_o, c_x_o, c_y_o, c_z_o};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign c_vld_i               = pipe[LAT-1][3*W] | inj;
    assign {c_x_i, c_y_i, c_z_i} = pipe[LAT-1][3*W-1:0];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_data0();
        s0_x = W'($urandom); s0_y = W'($urandom); s0_z = W'($urandom);
    endtask

    task automatic new_data1();
        s1_x = W'($urandom); s1_y = W'($urandom); s1_z = W'($urandom);
    endtask

    // One cycle of stimulus: expected results are queued at acceptance time.
    task automatic step(input bit en0, input bit en1);
        bit h0, h1;
        s0_vld = en0;
        s1_vld = en1;
        @(negedge clk);
        r0 = s0_rdy;
        r1 = s1_rdy;
        h0 = en0 && r0;
        h1 = en1 && r1;
        chk("gnt_onehot", {r0, r1} == 2'b11, 1'b0);
        if (h0) begin q0.push_back({s0_x, s0_y, s0_z}); gq.push_back(0); end
        if (h1) begin q1.push_back({s1_x, s1_y, s1_z}); gq.push_back(1); end
        @(posedge clk); #1;
        if (h0) new_data0();
        if (h1) new_data1();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_vld && m0_rdy) begin
                if (q0.size() == 0) chk("m0_unexpected", m0_vld, 1'b0);
                else begin e0 = q0.pop_front(); chk("m0_data", {m0_x, m0_y, m0_z}, e0); end
            end
            if (m1_vld && m1_rdy) begin
                if (q1.size() == 0) chk("m1_unexpected", m1_vld, 1'b0);
                else begin e1 = q1.pop_front(); chk("m1_data", {m1_x, m1_y, m1_z}, e1); end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt0, cnt1;
        bit seen;
        s0_vld = 0; s1_vld = 0; m0_rdy = 1; m1_rdy = 1; inj = 0;
        new_data0(); new_data1();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_vld", c_vld_o, 1'b0);
        chk("rst_c_x", c_x_o, '0);
        chk("rst_m0_vld", m0_vld, 1'b0);
        chk("rst_m1_vld", m1_vld, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // single request, identity model
        s0_x = 20'd1000; s0_y = '0; s0_z = '0;
        step(1, 0);
        chk("t1_rdy", r0, 1'b1);
        s0_vld = 0;
        @(negedge clk);
        chk("t1_c_vld", c_vld_o, 1'b1);
        chk("t1_c_x", c_x_o, 20'd1000);
        lat = 1; seen = 0;
        while (!m0_vld && lat < 40) begin
            @(negedge clk);
            lat++;
            if (m1_vld) seen = 1;
        end
        chk("t1_latency", lat, 18);
        chk("t1_m1_quiet", seen, 1'b0);
        @(posedge clk); #1;

        // both channels continuously valid: strict alternation from channel 0
        do_reset();
        gq.delete();
        repeat (8) step(1, 1);
        chk("t2_grants", gq.size(), 8);
        for (int i = 0; i < gq.size(); i++) chk("t2_order", gq[i], i % 2);
        repeat (30) step(0, 0);
        chk("t2_drain", q0.size() + q1.size(), 0);

        // m0 blocked: channel 0 limited to its credits, channel 1 keeps cycling
        m0_rdy = 0;
        gq.delete();
        repeat (40) step(1, 1);
        cnt0 = 0; cnt1 = 0;
        foreach (gq[i]) if (gq[i] == 0) cnt0++; else cnt1++;
        chk("t3_ch0_grants", cnt0, 4);
        chk("t3_ch1_grants", cnt1, 9);
        chk("t3_s0_blocked", r0, 1'b0);

        // pop and request on a credit-starved channel in the same cycle
        m0_rdy = 1;
        step(1, 0);
        chk("t4_same_cycle", r0, 1'b0);
        m0_rdy = 0;
        step(1, 0);
        chk("t4_next_cycle", r0, 1'b1);
        step(1, 0);
        chk("t4_regated", r0, 1'b0);
        m0_rdy = 1;
        gq.delete();
        repeat (30) step(1, 0);
        chk("t4_resumed", gq.size() > 4, 1'b1);
        repeat (40) step(0, 0);
        chk("t4_drain", q0.size() + q1.size(), 0);

        // spurious pipeline valid
        chk("t5_err_pre", err, 1'b0);
        inj = 1;
        @(posedge clk); #1;
        inj = 0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m0_vld || m1_vld) seen = 1;
        end
        chk("t5_err_set", err, 1'b1);
        chk("t5_m_quiet", seen, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_err_sticky", err, 1'b1);

        // reset with three operations in flight
        do_reset();
        chk("t6_err_cleared", err, 1'b0);
        step(1, 1);
        step(1, 1);
        step(1, 0);
        s0_vld = 0;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("t6_c_vld", c_vld_o, 1'b0);
        chk("t6_c_x", c_x_o, '0);
        chk("t6_m0_vld", m0_vld, 1'b0);
        chk("t6_m1_vld", m1_vld, 1'b0);
        chk("t6_err", err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m0_vld || m1_vld) seen = 1;
        end
        chk("t6_no_results", seen, 1'b0);
        chk("t6_err_clean", err, 1'b0);
        @(posedge clk); #1;
        m0_rdy = 0;
        gq.delete();
        repeat (10) step(1, 0);
        chk("t6_credits", gq.size(), 4);
        m0_rdy = 1;
        repeat (30) step(0, 0);
        chk("t6_drain", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
